// File: rtl/hazard_stall_unit_if.sv
// Decode-side bundle between the operand-usage decoder and the interlock stage.
// The master drives the decode-stage instruction; the slave returns stall/forward controls.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [1:0]       has_hazard;
  logic [1:0]       id_ra;
  logic [1:0]       id_rb;
  logic             id_wr_en;
  logic [1:0]       id_rd;
  logic             id_is_load;
  logic             flush;
  logic             stall;
  logic             bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, has_hazard, id_ra, id_rb, id_wr_en, id_rd, id_is_load, flush,
    input  stall, bubble, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_valid, has_hazard, id_ra, id_rb, id_wr_en, id_rd, id_is_load, flush,
    output stall, bubble, fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: tracks in-flight writers in an EX/MEM/WB shadow pipe and
// produces load-use stall, ID/EX bubble, per-operand forward selects and a stall counter.
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_unit_if.slave bus
);
  // Shadow stage index: 0 = EX, 1 = MEM, 2 = WB
  logic [2:0]       vld_reg;
  logic [2:0]       ld_reg;
  logic [1:0]       rd_reg [3];
  logic [CNT_W-1:0] count_reg;

  logic [1:0] op_live;
  logic [1:0] op_src [2];
  logic [1:0] fwd_sel [2];
  logic [1:0] use_stall;
  logic       stall_int;
  logic       issue_vld;

  // Operand 0 is a (has_hazard bit 1), operand 1 is b (has_hazard bit 0)
  assign op_live[0] = bus.id_valid & bus.has_hazard[1];
  assign op_live[1] = bus.id_valid & bus.has_hazard[0];
  assign op_src[0]  = bus.id_ra;
  assign op_src[1]  = bus.id_rb;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic [2:0] hit;
      logic [1:0] sel;

      for (genvar gj = 0; gj < 3; gj++) begin : g_stage
        assign hit[gj] = op_live[gi] & vld_reg[gj] & (rd_reg[gj] == op_src[gi]);
      end

      // Nearest stage wins so the youngest writer of a register is forwarded
      always_comb begin
        sel = 2'b00;
        if (hit[0])      sel = 2'b01;
        else if (hit[1]) sel = 2'b10;
        else if (hit[2]) sel = 2'b11;
      end

      assign fwd_sel[gi]   = sel;
      assign use_stall[gi] = hit[0] & ld_reg[0];
    end
  endgenerate

  assign stall_int = (|use_stall) & ~bus.flush;
  assign issue_vld = bus.id_valid & bus.id_wr_en & ~stall_int & ~bus.flush;

  assign bus.stall       = stall_int;
  assign bus.bubble      = stall_int | bus.flush;
  assign bus.fwd_a       = fwd_sel[0];
  assign bus.fwd_b       = fwd_sel[1];
  assign bus.stall_count = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg   <= 3'b000;
      ld_reg    <= 3'b000;
      rd_reg[0] <= 2'b00;
      rd_reg[1] <= 2'b00;
      rd_reg[2] <= 2'b00;
      count_reg <= '0;
    end else begin
      vld_reg   <= {vld_reg[1:0], issue_vld};
      ld_reg    <= {ld_reg[1:0], bus.id_is_load};
      rd_reg[2] <= rd_reg[1];
      rd_reg[1] <= rd_reg[0];
      rd_reg[0] <= bus.id_rd;
      if (stall_int && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed hazard scenarios plus random traffic,
// checked against a history-of-issued-writers reference model.
module tb_hazard_stall_unit;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_stall_unit_if #(.CNT_W(CW)) ifc ();

  hazard_stall_unit #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hist[k] = writer issued k+1 cycles ago (k=0 is the instruction now in EX)
  typedef struct {
    bit       v;
    bit [1:0] rd;
    bit       ld;
  } ent_t;

  ent_t hist [3];
  int   m_count;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_eval(output bit s, output bit [1:0] fa, output bit [1:0] fb);
    bit [1:0] sel [2];
    s = 1'b0;
    for (int op = 0; op < 2; op++) begin
      bit       live;
      bit [1:0] src;
      live = ifc.id_valid && (op == 0 ? ifc.has_hazard[1] : ifc.has_hazard[0]);
      src  = (op == 0) ? ifc.id_ra : ifc.id_rb;
      sel[op] = 2'b00;
      if (live) begin
        for (int age = 0; age < 3; age++) begin
          if (sel[op] == 2'b00 && hist[age].v && hist[age].rd == src) begin
            sel[op] = 2'(age + 1);
            if (age == 0 && hist[age].ld) s = 1'b1;
          end
        end
      end
    end
    if (ifc.flush) s = 1'b0;
    fa = sel[0];
    fb = sel[1];
  endfunction

  task automatic setin(input bit v, input bit [1:0] hh, input bit [1:0] ra, input bit [1:0] rb,
                       input bit we, input bit [1:0] rd, input bit ld, input bit fl, input bit r);
    ifc.id_valid   = v;
    ifc.has_hazard = hh;
    ifc.id_ra      = ra;
    ifc.id_rb      = rb;
    ifc.id_wr_en   = we;
    ifc.id_rd      = rd;
    ifc.id_is_load = ld;
    ifc.flush      = fl;
    rst            = r;
  endtask

  task automatic setrand(input bit r);
    setin(1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
          2'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), r);
  endtask

  // Inputs are set just after a falling edge; check mid-cycle, then advance the model at the rising edge
  task automatic step(input bit do_chk);
    bit       es;
    bit [1:0] ea;
    bit [1:0] eb;
    #1;
    model_eval(es, ea, eb);
    if (do_chk) begin
      chk("stall", 16'(ifc.stall), 16'(es));
      chk("bubble", 16'(ifc.bubble), 16'(es | ifc.flush));
      chk("fwd_a", 16'(ifc.fwd_a), 16'(ea));
      chk("fwd_b", 16'(ifc.fwd_b), 16'(eb));
      chk("stall_count", 16'(ifc.stall_count), 16'(m_count));
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[k] = '{v: 1'b0, rd: 2'b00, ld: 1'b0};
      m_count = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{v: ifc.id_valid && ifc.id_wr_en && !es && !ifc.flush,
                  rd: ifc.id_rd, ld: ifc.id_is_load};
      if (es && m_count < (1 << CW) - 1) m_count++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    setin(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m_count = 0;
    for (int k = 0; k < 3; k++) hist[k] = '{v: 1'b0, rd: 2'b00, ld: 1'b0};
    setrand(1'b1);
    @(negedge clk);

    // Reset held two cycles with random inputs; state is unknown before the first edge
    setrand(1'b1);
    step(1'b0);
    setrand(1'b1);
    step(1'b1);
    setin(1'b1, 2'b11, 2'b01, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_stall", 16'(ifc.stall), 16'h0);
    chk("rst_fwd_a", 16'(ifc.fwd_a), 16'h0);
    chk("rst_fwd_b", 16'(ifc.fwd_b), 16'h0);
    chk("rst_count", 16'(ifc.stall_count), 16'h0);
    step(1'b1);

    // ALU->ALU forwarding through EX, MEM, WB, then register file
    idle(); idle(); idle();
    setin(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    setin(1'b1, 2'b10, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("alu_ex_fwd_a", 16'(ifc.fwd_a), 16'h1);
    step(1'b1);
    #1;
    chk("alu_mem_fwd_a", 16'(ifc.fwd_a), 16'h2);
    step(1'b1);
    #1;
    chk("alu_wb_fwd_a", 16'(ifc.fwd_a), 16'h3);
    step(1'b1);
    #1;
    chk("alu_rf_fwd_a", 16'(ifc.fwd_a), 16'h0);
    step(1'b1);

    // Load-use on operand b: one stall then MEM forwarding
    idle(); idle(); idle();
    setin(1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    setin(1'b1, 2'b01, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_stall", 16'(ifc.stall), 16'h1);
    chk("lu_bubble", 16'(ifc.bubble), 16'h1);
    step(1'b1);
    #1;
    chk("lu_release", 16'(ifc.stall), 16'h0);
    chk("lu_fwd_b", 16'(ifc.fwd_b), 16'h2);
    chk("lu_count", 16'(ifc.stall_count), 16'h1);
    step(1'b1);

    // Unused operand must not stall
    setin(1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    setin(1'b1, 2'b00, 2'd3, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1);

    // Back-to-back writers to r0: nearest wins
    setin(1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    step(1'b1);
    setin(1'b1, 2'b10, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("prio_fwd_a", 16'(ifc.fwd_a), 16'h1);
    step(1'b1);

    // Flush overrides a load-use stall; the flushed writer never enters EX
    idle(); idle(); idle();
    setin(1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    setin(1'b1, 2'b10, 2'd1, 2'd0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_stall", 16'(ifc.stall), 16'h0);
    chk("flush_bubble", 16'(ifc.bubble), 16'h1);
    step(1'b1);
    setin(1'b1, 2'b01, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush_ex_empty", 16'(ifc.fwd_b), 16'h0);
    step(1'b1);

    // Reset in the middle of a stall clears everything
    setin(1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    setin(1'b1, 2'b11, 2'd2, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    setin(1'b1, 2'b11, 2'd2, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("midrst_stall", 16'(ifc.stall), 16'h0);
    chk("midrst_count", 16'(ifc.stall_count), 16'h0);
    step(1'b1);

    // Twenty load-use stalls saturate a 4-bit counter
    for (int n = 0; n < 20; n++) begin
      setin(1'b1, 2'b00, 2'd0, 2'd0, 1'b1, 2'(n), 1'b1, 1'b0, 1'b0);
      step(1'b1);
      setin(1'b1, 2'b11, 2'(n), 2'(n), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1);
      step(1'b1);
    end
    idle();
    #1;
    chk("sat_count", 16'(ifc.stall_count), 16'hF);
    @(negedge clk);

    // Random traffic, with an occasional reset
    for (int n = 0; n < 400; n++) begin
      setrand($urandom_range(0, 63) == 0);
      step(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
